// File: rtl/contactor_pkg.sv
// Shared state encodings and fault codes for the contactor drive stage.
package contactor_pkg;

  typedef enum logic [2:0] {
    ST_OPEN    = 3'd0,
    ST_CLOSING = 3'd1,
    ST_CLOSED  = 3'd2,
    ST_OPENING = 3'd3,
    ST_FAULT   = 3'd4
  } state_e;

  localparam logic [1:0] FC_NONE       = 2'b00;
  localparam logic [1:0] FC_FAIL_CLOSE = 2'b01;
  localparam logic [1:0] FC_FAIL_OPEN  = 2'b10;
  localparam logic [1:0] FC_DROPOUT    = 2'b11;

  // The coil is energised only while the contactor is being closed or held closed.
  function automatic logic coil_on(input state_e s);
    return (s == ST_CLOSING) || (s == ST_CLOSED);
  endfunction

endpackage

// File: rtl/feedback_debounce.sv
// Two-flop synchroniser followed by a stability filter for the auxiliary contact.
module feedback_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_fb
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          fb_q;
  logic [CW-1:0] cnt_q;

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      fb_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_raw;
      sync2_q <= sync1_q;
      if (sync2_q == fb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        fb_q  <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign o_fb = fb_q;

endmodule

// File: rtl/contactor_sequencer.sv
// Per-contactor coil sequencer with close/open supervision and latched faults.
// Optional close retry is enabled by defining CONTACTOR_RETRY_EN.
module contactor_sequencer
  import contactor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CLOSE_TIMEOUT   = 1000,
  parameter int OPEN_TIMEOUT    = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd,
  input  logic       i_permit,
  input  logic       i_fb_raw,
  input  logic       i_fault_clr,
  output logic       o_coil,
  output logic       o_fb,
  output logic       o_closed,
  output logic       o_fault,
  output logic [1:0] o_fault_code,
  output logic [2:0] o_state
);

  localparam int TMAX = (CLOSE_TIMEOUT > OPEN_TIMEOUT) ? CLOSE_TIMEOUT : OPEN_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    code_q, code_d;
  logic          coil_q, closed_q, fault_q;
  logic          fb;
  logic          run_ok;

  feedback_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_raw (i_fb_raw),
    .o_fb  (fb)
  );

  assign run_ok = i_cmd && i_permit;

`ifdef CONTACTOR_RETRY_EN
  logic retry_q, retry_d;
`endif

  // NOTE: every signal gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
`ifdef CONTACTOR_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      ST_OPEN: begin
        if (fb) begin
          state_d = ST_FAULT;
          code_d  = FC_FAIL_OPEN;
        end else if (run_ok) begin
          state_d = ST_CLOSING;
        end
      end
      ST_CLOSING: begin
        if (!run_ok) begin
          state_d = ST_OPENING;
        end else if (fb) begin
          state_d = ST_CLOSED;
        end else if (timer_q == TW'(CLOSE_TIMEOUT - 1)) begin
`ifdef CONTACTOR_RETRY_EN
          if (!retry_q) begin
            state_d = ST_OPENING;
            retry_d = 1'b1;
          end else begin
            state_d = ST_FAULT;
            code_d  = FC_FAIL_CLOSE;
          end
`else
          state_d = ST_FAULT;
          code_d  = FC_FAIL_CLOSE;
`endif
        end
      end
      ST_CLOSED: begin
        if (!run_ok) begin
          state_d = ST_OPENING;
        end else if (!fb) begin
          state_d = ST_FAULT;
          code_d  = FC_DROPOUT;
        end
      end
      ST_OPENING: begin
        if (!fb) begin
          state_d = ST_OPEN;
        end else if (timer_q == TW'(OPEN_TIMEOUT - 1)) begin
          state_d = ST_FAULT;
          code_d  = FC_FAIL_OPEN;
        end
      end
      ST_FAULT: begin
        if (i_fault_clr && !i_cmd && !fb) begin
          state_d = ST_OPEN;
          code_d  = FC_NONE;
        end
      end
      default: state_d = ST_OPEN;
    endcase
`ifdef CONTACTOR_RETRY_EN
    if (!i_cmd || state_d == ST_CLOSED) retry_d = 1'b0;
`endif

    // Timer restarts on every state entry and only advances while a transition is supervised.
    if (state_d != state_q)
      timer_d = '0;
    else if (state_q == ST_CLOSING || state_q == ST_OPENING)
      timer_d = timer_q + TW'(1);
    else
      timer_d = timer_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_OPEN;
      timer_q  <= '0;
      code_q   <= FC_NONE;
      coil_q   <= 1'b0;
      closed_q <= 1'b0;
      fault_q  <= 1'b0;
`ifdef CONTACTOR_RETRY_EN
      retry_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      code_q   <= code_d;
      coil_q   <= coil_on(state_d);
      closed_q <= (state_d == ST_CLOSED);
      fault_q  <= (state_d == ST_FAULT);
`ifdef CONTACTOR_RETRY_EN
      retry_q  <= retry_d;
`endif
    end
  end

  assign o_coil       = coil_q;
  assign o_fb         = fb;
  assign o_closed     = closed_q;
  assign o_fault      = fault_q;
  assign o_fault_code = code_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_contactor_sequencer.sv
// Directed bench for contactor_sequencer with DEBOUNCE_CYCLES=4 and 20-cycle timeouts.
module tb_contactor_sequencer;

  logic       clk = 1'b0;
  logic       rst, cmd, permit, fb_raw, fault_clr;
  logic       coil, fb, closed, fault;
  logic [1:0] code;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] S_OPEN = 3'd0, S_CLOSING = 3'd1, S_CLOSED = 3'd2,
                         S_OPENING = 3'd3, S_FAULT = 3'd4;

  contactor_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .CLOSE_TIMEOUT  (20),
    .OPEN_TIMEOUT   (20)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cmd       (cmd),
    .i_permit    (permit),
    .i_fb_raw    (fb_raw),
    .i_fault_clr (fault_clr),
    .o_coil      (coil),
    .o_fb        (fb),
    .o_closed    (closed),
    .o_fault     (fault),
    .o_fault_code(code),
    .o_state     (state)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st, input logic c,
                            input logic cl, input logic f, input logic [1:0] fc);
    check({tag, ".state"}, {1'b0, state}, {1'b0, st});
    check({tag, ".coil"},  {3'b0, coil},  {3'b0, c});
    check({tag, ".closed"},{3'b0, closed},{3'b0, cl});
    check({tag, ".fault"}, {3'b0, fault}, {3'b0, f});
    check({tag, ".code"},  {2'b0, code},  {2'b0, fc});
  endtask

  initial begin
    rst = 1'b1; cmd = 1'b0; permit = 1'b0; fb_raw = 1'b0; fault_clr = 1'b0;
    step(2);
    check_outs("reset", S_OPEN, 1'b0, 1'b0, 1'b0, 2'b00);
    check("reset.fb", {3'b0, fb}, 4'h0);
    rst = 1'b0;

    // Normal close / open cycle
    cmd = 1'b1; permit = 1'b1;
    step(1);
    check_outs("close_entry", S_CLOSING, 1'b1, 1'b0, 1'b0, 2'b00);
    step(4);
    fb_raw = 1'b1;
    step(5);
    check("deb_rise_5", {3'b0, fb}, 4'h0);
    step(1);
    check("deb_rise_6", {3'b0, fb}, 4'h1);
    check("still_closing", {1'b0, state}, {1'b0, S_CLOSING});
    step(1);
    check_outs("closed", S_CLOSED, 1'b1, 1'b1, 1'b0, 2'b00);
    cmd = 1'b0;
    step(1);
    check_outs("opening", S_OPENING, 1'b0, 1'b0, 1'b0, 2'b00);
    fb_raw = 1'b0;
    step(5);
    check("deb_fall_5", {3'b0, fb}, 4'h1);
    step(1);
    check("deb_fall_6", {3'b0, fb}, 4'h0);
    step(1);
    check_outs("opened", S_OPEN, 1'b0, 1'b0, 1'b0, 2'b00);

    // 3-cycle glitch rejected
    fb_raw = 1'b1;
    step(3);
    fb_raw = 1'b0;
    step(8);
    check("glitch3.fb", {3'b0, fb}, 4'h0);
    check_outs("glitch3", S_OPEN, 1'b0, 1'b0, 1'b0, 2'b00);

    // 4-cycle pulse passes the filter; feedback while OPEN means a welded contact
    fb_raw = 1'b1;
    step(4);
    fb_raw = 1'b0;
    step(3);
    check_outs("weld_in_open", S_FAULT, 1'b0, 1'b0, 1'b1, 2'b10);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check("clr_ignored_fb_high", {1'b0, state}, {1'b0, S_FAULT});
    step(4);
    check("fb_low_again", {3'b0, fb}, 4'h0);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check_outs("weld_cleared", S_OPEN, 1'b0, 1'b0, 1'b0, 2'b00);

    // Close timeout: feedback never rises
    cmd = 1'b1; permit = 1'b1;
    step(1);
    check("to.entry", {1'b0, state}, {1'b0, S_CLOSING});
    step(19);
    check("to.edge19", {1'b0, state}, {1'b0, S_CLOSING});
    step(1);
`ifdef CONTACTOR_RETRY_EN
    check_outs("to.retry_opening", S_OPENING, 1'b0, 1'b0, 1'b0, 2'b00);
    step(1);
    check("to.retry_open", {1'b0, state}, {1'b0, S_OPEN});
    step(1);
    check_outs("to.retry_closing", S_CLOSING, 1'b1, 1'b0, 1'b0, 2'b00);
    step(19);
    check("to.retry_edge19", {1'b0, state}, {1'b0, S_CLOSING});
    step(1);
`endif
    check_outs("to.fault", S_FAULT, 1'b0, 1'b0, 1'b1, 2'b01);
    cmd = 1'b0;
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check_outs("to.cleared", S_OPEN, 1'b0, 1'b0, 1'b0, 2'b00);

    // Welded contact: fb stays high through OPENING
    cmd = 1'b1;
    step(1);
    fb_raw = 1'b1;
    step(7);
    check("weld.closed", {1'b0, state}, {1'b0, S_CLOSED});
    cmd = 1'b0;
    step(1);
    check_outs("weld.opening", S_OPENING, 1'b0, 1'b0, 1'b0, 2'b00);
    step(19);
    check("weld.edge19", {1'b0, state}, {1'b0, S_OPENING});
    step(1);
    check_outs("weld.fault", S_FAULT, 1'b0, 1'b0, 1'b1, 2'b10);
    fb_raw = 1'b0;
    step(8);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check_outs("weld.cleared", S_OPEN, 1'b0, 1'b0, 1'b0, 2'b00);

    // Drop-out in CLOSED, then clear attempts
    cmd = 1'b1;
    step(1);
    fb_raw = 1'b1;
    step(7);
    check("drop.closed", {1'b0, state}, {1'b0, S_CLOSED});
    fb_raw = 1'b0;
    step(6);
    check("drop.still_closed", {1'b0, state}, {1'b0, S_CLOSED});
    step(1);
    check_outs("drop.fault", S_FAULT, 1'b0, 1'b0, 1'b1, 2'b11);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check_outs("drop.clr_cmd_high", S_FAULT, 1'b0, 1'b0, 1'b1, 2'b11);
    cmd = 1'b0;
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check_outs("drop.cleared", S_OPEN, 1'b0, 1'b0, 1'b0, 2'b00);

    // Permit loss during CLOSING aborts
    cmd = 1'b1; permit = 1'b1;
    step(1);
    check("permit.closing", {1'b0, state}, {1'b0, S_CLOSING});
    step(3);
    permit = 1'b0;
    step(1);
    check_outs("permit.opening", S_OPENING, 1'b0, 1'b0, 1'b0, 2'b00);
    step(1);
    check("permit.open", {1'b0, state}, {1'b0, S_OPEN});

    // Reset while CLOSED
    permit = 1'b1;
    step(1);
    fb_raw = 1'b1;
    step(7);
    check_outs("rst.closed", S_CLOSED, 1'b1, 1'b1, 1'b0, 2'b00);
    rst = 1'b1;
    step(1);
    check_outs("rst.mid", S_OPEN, 1'b0, 1'b0, 1'b0, 2'b00);
    check("rst.fb", {3'b0, fb}, 4'h0);
    cmd = 1'b0; fb_raw = 1'b0;
    step(1);
    rst = 1'b0;
    step(2);
    check_outs("rst.idle", S_OPEN, 1'b0, 1'b0, 1'b0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/contactor_sequencer.md
Name: contactor_sequencer

Overview:
- Per-contactor drive stage that sits directly downstream of each ring interlock block (one instance per contactor A–H).
- Consumes the interlock permit and the operator close command, drives the contactor coil, and debounces the auxiliary feedback contact.
- The debounced feedback feeds the interlock inputs of all neighbouring contactors.
- Supervises close/open timing and latches faults.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable cycles of synchronised feedback required before the filtered feedback changes.
- CLOSE_TIMEOUT, 1000: cycles allowed in CLOSING for feedback to assert.
- OPEN_TIMEOUT, 1000: cycles allowed in OPENING for feedback to deassert.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  synchronous, active-high reset
- i_cmd  input  1  close request for this contactor
- i_permit  input  1  interlock permit (1 = closing allowed)
- i_fb_raw  input  1  raw auxiliary contact, asynchronous
- i_fault_clr  input  1  fault acknowledge pulse
- o_coil  output  1  coil drive
- o_fb  output  1  debounced feedback, routed to the interlock blocks
- o_closed  output  1  contactor confirmed closed
- o_fault  output  1  latched fault
- o_fault_code  output  2  00 none, 01 fail-to-close, 10 fail-to-open/welded, 11 unexpected drop-out
- o_state  output  3  current FSM state encoding

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: state OPEN; o_coil, o_fb, o_closed, o_fault = 0; o_fault_code = 00; sync flops, debounce counter and timer = 0.
- Reset mid-operation: o_coil drops on the next edge.
- Feedback path:
  - 2-flop synchroniser, then filter.
  - The debounce counter clears whenever the synchronised value equals o_fb, and increments otherwise.
  - o_fb takes the new value on the edge after the counter reaches DEBOUNCE_CYCLES-1.
  - A stable raw change appears on o_fb exactly DEBOUNCE_CYCLES+2 edges later. Glitches shorter than DEBOUNCE_CYCLES are rejected.
- Timer: counts cycles in CLOSING and OPENING, and clears on every state entry. Width is $clog2(max(CLOSE_TIMEOUT,OPEN_TIMEOUT)+1).
- OPEN (coil=0):
  - o_fb=1 → FAULT, code 10. This check has priority.
  - else i_cmd & i_permit → CLOSING.
- CLOSING (coil=1):
  - ~i_cmd | ~i_permit → OPENING (abort).
  - else o_fb → CLOSED.
  - else timer==CLOSE_TIMEOUT-1 → FAULT, code 01.
- CLOSED (coil=1, o_closed=1):
  - ~i_cmd | ~i_permit → OPENING. This has priority over drop-out.
  - else ~o_fb → FAULT, code 11.
- OPENING (coil=0):
  - ~o_fb → OPEN.
  - else timer==OPEN_TIMEOUT-1 → FAULT, code 10.
- FAULT (coil=0, o_fault=1, code held):
  - i_fault_clr & ~i_cmd & ~o_fb → OPEN; code clears to 00.
  - otherwise i_fault_clr is ignored.
- All outputs are registered; o_coil changes on the edge that enters the state.

Optional Feature:
- Macro: CONTACTOR_RETRY_EN.
- Defined:
  - The first close timeout goes to OPENING (not FAULT) and sets a retry flag.
  - On reaching OPEN with i_cmd & i_permit still asserted, CLOSING re-enters.
  - A second consecutive close timeout → FAULT, code 01.
  - The retry flag clears on entering CLOSED, on i_cmd=0, or on reset.
  - A timeout in the OPENING leg of a retry → FAULT, code 10.
- Undefined: the first close timeout faults immediately; no retry flag is implemented.

Decomposition:
- Package contactor_pkg:
  - state encodings OPEN=0, CLOSING=1, CLOSED=2, OPENING=3, FAULT=4;
  - fault code constants FC_NONE, FC_FAIL_CLOSE, FC_FAIL_OPEN, FC_DROPOUT.
- Sub-module feedback_debounce (synchroniser + filter, parameter DEBOUNCE_CYCLES), instantiated once.

Test Plan (DEBOUNCE_CYCLES=4, CLOSE_TIMEOUT=20, OPEN_TIMEOUT=20):
- Normal cycle:
  - i_cmd=1, i_permit=1 → o_coil=1 next edge.
  - Raw fb rises 5 cycles later → o_fb=1 six edges after the rise, then o_closed=1.
  - i_cmd=0 → o_coil=0; fb falls → OPEN.
- Glitch rejection: 3-cycle raw fb pulse while OPEN → o_fb stays 0, no fault.
- Close timeout: fb never rises → FAULT, code 01, o_coil=0 exactly 20 cycles after CLOSING entry. With CONTACTOR_RETRY_EN, a second CLOSING attempt precedes the fault.
- Welded contact: in CLOSED, deassert i_cmd with fb held 1 → FAULT, code 10 after 20 cycles in OPENING.
- Drop-out and clear:
  - In CLOSED, fb falls with cmd/permit held → FAULT, code 11.
  - i_fault_clr while i_cmd=1 → stays in FAULT.
  - i_cmd=0 then i_fault_clr → OPEN, code 00.
- Permit loss and reset: i_permit drops during CLOSING → OPENING next edge; i_rst asserted in CLOSED → all outputs 0, state OPEN.
